i2c_master_ctrl: RTL and testbench

- Single-byte I2C master transaction sequencer. Sits between host logic and the open-drain SCL/SDA pads.
- Generates SCL internally from a quarter-period tick derived from ref_clk; no divided clock is produced.
- Sequences START, 7-bit address + R/W, ACK, one data byte (write or read), ACK/NACK, STOP.
- Reports completion, ACK error and read data back to the host.

---
 rtl/i2c_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL/SDA are registered and derived from a quarter-period tick; host handshake is start/busy/done.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  output logic       sda_pull,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'(CLK_DIV - 1);

  state_t     state, nstate;
  logic [9:0] cnt;
  logic [1:0] qidx, nq;
  logic [2:0] bitcnt, nbit;
  logic [7:0] addr_l, wdata_l, rshift;
  logic       samp, tick, nbv, nscl, npull;

  assign tick = (state != IDLE) && (cnt == CNT_MAX);

  always_comb begin
    nstate = state;
    nq     = qidx;
    nbit   = bitcnt;
    if (state == IDLE) begin
      if (start) begin
        nstate = START;
        nq     = 2'd0;
      end
    end else if (tick) begin
      nq = qidx + 2'd1;
      if (qidx == 2'd3) begin
        case (state)
          START: begin
            nstate = ADDR;
            nbit   = 3'd7;
          end
          ADDR: begin
            if (bitcnt == 3'd0) begin
              nstate = ADDR_ACK;
              nbit   = 3'd7;
            end else begin
              nbit = bitcnt - 3'd1;
            end
          end
          ADDR_ACK:   nstate = samp ? STOP : (addr_l[0] ? RDATA : WDATA);
          WDATA: begin
            if (bitcnt == 3'd0) begin
              nstate = WDATA_ACK;
              nbit   = 3'd7;
            end else begin
              nbit = bitcnt - 3'd1;
            end
          end
          WDATA_ACK:  nstate = STOP;
          RDATA: begin
            if (bitcnt == 3'd0) begin
              nstate = RDATA_NACK;
              nbit   = 3'd7;
            end else begin
              nbit = bitcnt - 3'd1;
            end
          end
          RDATA_NACK: nstate = STOP;
          STOP:       nstate = IDLE;
          default:    nstate = IDLE;
        endcase
      end
    end
  end

  // Pad levels for the state/quarter about to be entered, so the outputs are plain flops.
  always_comb begin
    nbv   = 1'b1;
    nscl  = 1'b1;
    npull = 1'b0;
    case (nstate)
      ADDR:  nbv = addr_l[nbit];
      WDATA: nbv = wdata_l[nbit];
      default: nbv = 1'b1;
    endcase
    case (nstate)
      IDLE: begin
        nscl  = 1'b1;
        npull = 1'b0;
      end
      START: begin
        nscl  = (nq != 2'd3);
        npull = nq[1];
      end
      STOP: begin
        nscl  = (nq != 2'd0);
        npull = ~nq[1];
      end
      default: begin
        nscl  = (nq == 2'd1) || (nq == 2'd2);
        npull = ~nbv;
      end
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 10'd0;
      qidx     <= 2'd0;
      bitcnt   <= 3'd7;
      addr_l   <= 8'd0;
      wdata_l  <= 8'd0;
      rshift   <= 8'd0;
      samp     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= 8'd0;
      scl      <= 1'b1;
      sda_pull <= 1'b0;
    end else begin
      state    <= nstate;
      qidx     <= nq;
      bitcnt   <= nbit;
      scl      <= nscl;
      sda_pull <= npull;
      done     <= 1'b0;
      if (state == IDLE || tick) cnt <= 10'd0;
      else                       cnt <= cnt + 10'd1;
      if (state == IDLE && start) begin
        addr_l  <= {addr, rw};
        wdata_l <= wdata;
        busy    <= 1'b1;
        ack_err <= 1'b0;
      end
      // SDA is sampled in the middle of the SCL high phase.
      if (tick && qidx == 2'd1) begin
        samp <= sda_in;
        if ((state == ADDR_ACK || state == WDATA_ACK) && sda_in) ack_err <= 1'b1;
        if (state == RDATA) rshift <= {rshift[6:0], sda_in};
      end
      if (tick && qidx == 2'd3 && state == STOP) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (addr_l[0]) rdata <= rshift;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a per-quarter waveform model built from the transaction's slot list,
// checked every cycle, plus literal pins on cycle counts and bit sequences.
module tb_i2c_master_ctrl;
  localparam int D = 4;

  logic       ref_clk = 1'b0;
  logic       reset, start, rw, busy, done, ack_err, scl, sda_pull, sda_in;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .ref_clk(ref_clk), .reset(reset), .start(start), .addr(addr), .rw(rw),
    .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl(scl), .sda_pull(sda_pull), .sda_in(sda_in)
  );

  always #5 ref_clk = ~ref_clk;

  int tests = 0, fails = 0;
  bit qscl[$], qpull[$], sl[$];
  int nq_tot;
  bit t_rw, t_aack, exp_ae;
  logic [7:0] t_rb;
  bit active;
  int n;
  bit held_ae, rd_known;
  logic [7:0] held_rd;
  logic [17:0] cap;
  int rise[$];
  logic prev_scl;

  function automatic void chk(string name, bit ok, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic add_slot(input bit [3:0] s, input bit [3:0] p, input bit sv);
    for (int q = 0; q < 4; q++) begin
      qscl.push_back(s[2'(3 - q)]);
      qpull.push_back(p[2'(3 - q)]);
    end
    sl.push_back(sv);
  endtask

  // One slot = 4 quarters; each slot also carries what the slave puts on SDA.
  task automatic build(input logic [6:0] a, input logic r, input logic [7:0] w,
                       input logic aack, input logic dack, input logic [7:0] rb);
    logic [7:0] ab;
    ab = {a, r};
    qscl.delete(); qpull.delete(); sl.delete();
    add_slot(4'b1110, 4'b0011, 1'b1);
    for (int i = 7; i >= 0; i--) add_slot(4'b0110, {4{~ab[3'(i)]}}, 1'b1);
    add_slot(4'b0110, 4'b0000, aack);
    if (!aack) begin
      if (!r) begin
        for (int i = 7; i >= 0; i--) add_slot(4'b0110, {4{~w[3'(i)]}}, 1'b1);
        add_slot(4'b0110, 4'b0000, dack);
      end else begin
        for (int i = 7; i >= 0; i--) add_slot(4'b0110, 4'b0000, rb[3'(i)]);
        add_slot(4'b0110, 4'b0000, 1'b1);
      end
    end
    add_slot(4'b0111, 4'b1100, 1'b1);
    nq_tot = qscl.size();
    t_rw   = r;
    t_aack = aack;
    t_rb   = rb;
    exp_ae = aack | (~r & dack);
  endtask

  task automatic monitor();
    int qi, slot;
    forever begin
      @(negedge ref_clk);
      if (!reset) begin
        if (active) begin
          if (n <= nq_tot * D) begin
            qi = (n - 1) / D;
            chk("wave", {scl, sda_pull, busy, done} === {qscl[qi], qpull[qi], 2'b10},
                32'({scl, sda_pull, busy, done}), 32'({qscl[qi], qpull[qi], 2'b10}));
            if ((n - 1) % (4 * D) == D) begin
              slot = (n - 1) / (4 * D);
              if (slot >= 1 && slot <= 18) cap[5'(18 - slot)] = ~sda_pull;
            end
            if (n > 4 * D && scl === 1'b1 && prev_scl === 1'b0) rise.push_back(n);
          end else begin
            chk("done_pulse", {done, busy, scl, sda_pull} === 4'b1010,
                32'({done, busy, scl, sda_pull}), 32'(4'b1010));
            chk("ack_err_at_done", ack_err === exp_ae, 32'(ack_err), 32'(exp_ae));
            held_ae = exp_ae;
            if (t_rw) begin
              if (!t_aack) begin
                held_rd  = t_rb;
                rd_known = 1'b1;
              end else begin
                rd_known = 1'b0;
              end
            end
            if (rd_known) chk("rdata_at_done", rdata === held_rd, 32'(rdata), 32'(held_rd));
            active = 1'b0;
          end
          n++;
        end else begin
          chk("idle", {busy, done, scl, sda_pull, ack_err} === {4'b0010, held_ae},
              32'({busy, done, scl, sda_pull, ack_err}), 32'({4'b0010, held_ae}));
          if (rd_known) chk("rdata_hold", rdata === held_rd, 32'(rdata), 32'(held_rd));
        end
      end
      prev_scl = scl;
      sda_in = (active && n <= nq_tot * D) ? sl[(n - 1) / (4 * D)] : 1'b1;
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w,
                        input logic aack, input logic dack, input logic [7:0] rb);
    @(posedge ref_clk);
    build(a, r, w, aack, dack, rb);
    cap = '0;
    rise.delete();
    @(negedge ref_clk);
    start = 1'b1; addr = a; rw = r; wdata = w;
    @(posedge ref_clk);
    #1;
    start  = 1'b0;
    active = 1'b1;
    n      = 1;
  endtask

  task automatic wait_done(input bit pulse, output int k);
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ref_clk);
      k++;
      if (pulse && k < nq_tot * D - 2 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        addr  = 7'($urandom);
        rw    = 1'($urandom_range(0, 1));
        wdata = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) chk("done_timeout", 1'b0, 32'(k), 32'(nq_tot * D + 1));
  endtask

  initial begin
    int k, per;
    logic [6:0] ra;
    logic [7:0] rw8, rb8;
    logic rr, raack, rdack;
    bit rp;
    reset = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0; sda_in = 1'b1;
    active = 1'b0; n = 0; held_ae = 1'b0; held_rd = 8'h00; rd_known = 1'b1; prev_scl = 1'b1;
    cap = '0;
    repeat (3) @(posedge ref_clk);
    #1;
    chk("reset_vals", {busy, done, ack_err, scl, sda_pull} === 5'b00010,
        32'({busy, done, ack_err, scl, sda_pull}), 32'(5'b00010));
    chk("reset_rdata", rdata === 8'h00, 32'(rdata), 32'h0);
    reset = 1'b0;
    fork
      monitor();
    join_none

    // Write 0x50 / 0xA5, both ACKs low.
    launch(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    wait_done(1'b0, k);
    chk("wr_done_cycle", k == 321, 32'(k), 32'd321);
    chk("wr_ack_err", ack_err === 1'b0, 32'(ack_err), 32'd0);
    chk("wr_sda_bits", cap === 18'b10100000_1_10100101_1, 32'(cap), 32'(18'b10100000_1_10100101_1));
    per = (rise.size() >= 2) ? rise[1] - rise[0] : -1;
    chk("scl_period", per == 16, 32'(per), 32'd16);

    // Read 0x3C, slave returns 0x96.
    launch(7'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96);
    wait_done(1'b0, k);
    chk("rd_done_cycle", k == 321, 32'(k), 32'd321);
    chk("rd_rdata", rdata === 8'h96, 32'(rdata), 32'h96);
    chk("rd_ack_err", ack_err === 1'b0, 32'(ack_err), 32'd0);
    chk("rd_addr_bits", cap[17:9] === 9'b01111001_1, 32'(cap[17:9]), 32'(9'b01111001_1));
    chk("rd_released", cap[8:0] === 9'h1FF, 32'(cap[8:0]), 32'h1FF);

    // Address NACK.
    launch(7'h2B, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00);
    wait_done(1'b0, k);
    chk("anack_done_cycle", k == 177, 32'(k), 32'd177);
    chk("anack_ack_err", ack_err === 1'b1, 32'(ack_err), 32'd1);

    // Data NACK on write; ack_err must persist while idle.
    launch(7'h11, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h00);
    wait_done(1'b0, k);
    chk("dnack_done_cycle", k == 321, 32'(k), 32'd321);
    chk("dnack_ack_err", ack_err === 1'b1, 32'(ack_err), 32'd1);
    repeat (10) @(negedge ref_clk);
    chk("dnack_hold", ack_err === 1'b1, 32'(ack_err), 32'd1);

    // Start pulses while busy must be ignored.
    launch(7'h5A, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
    wait_done(1'b1, k);
    chk("busy_start_done_cycle", k == 321, 32'(k), 32'd321);

    // Reset during WDATA bit 3 (slot 14), then a clean transaction.
    launch(7'h22, 1'b0, 8'hF0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 1000 && n < 230; i++) @(negedge ref_clk);
    @(posedge ref_clk);
    #1;
    reset  = 1'b1;
    active = 1'b0;
    @(posedge ref_clk);
    #1;
    chk("abort_vals", {scl, sda_pull, busy, done} === 4'b1000,
        32'({scl, sda_pull, busy, done}), 32'(4'b1000));
    reset    = 1'b0;
    held_ae  = 1'b0;
    held_rd  = 8'h00;
    rd_known = 1'b1;
    launch(7'h33, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h00);
    wait_done(1'b0, k);
    chk("post_reset_done_cycle", k == 321, 32'(k), 32'd321);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      ra    = 7'($urandom);
      rr    = 1'($urandom_range(0, 1));
      rw8   = 8'($urandom);
      rb8   = 8'($urandom);
      raack = ($urandom_range(0, 3) == 0);
      rdack = 1'($urandom_range(0, 1));
      rp    = 1'($urandom_range(0, 1));
      launch(ra, rr, rw8, raack, rdack, rb8);
      wait_done(rp, k);
      chk("rand_done_cycle", k == (raack ? 44 : 80) * D + 1, 32'(k), 32'((raack ? 44 : 80) * D + 1));
    end

    repeat (5) @(negedge ref_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
